// File: rtl/hazard_ctrl.sv
// Decode-stage hazard controller: per-register in-flight write scoreboard with RAW/WAW stall,
// instruction-bus hold arbitration and execute redirect handling for pc, if_id and id_ex.
module hazard_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid_i,
    input  logic [4:0]  rs1_addr_i,
    input  logic [4:0]  rs2_addr_i,
    input  logic        rs1_used_i,
    input  logic        rs2_used_i,
    input  logic [4:0]  rd_addr_i,
    input  logic        reg_wen_i,
    input  logic [4:0]  wb_rd_addr_i,
    input  logic        wb_reg_wen_i,
    input  logic        jump_en_i,
    input  logic        hold_req_i,
    output logic        hold_pc_o,
    output logic        hold_if_id_o,
    output logic        bubble_id_ex_o,
    output logic        flush_if_id_o,
    output logic        flush_id_ex_o,
    output logic        jump_fire_o,
    output logic [1:0]  state_o,
    output logic [31:0] stall_cnt_o,
    output logic        sb_err_o
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        RAW   = 2'd1,
        BUS   = 2'd2,
        JPEND = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [1:0]  r_cnt [0:31];
    logic [31:0] r_stall_cnt;
    logic        r_sb_err;

    logic        w_ret_act;
    logic        w_ret_ok;
    logic [1:0]  w_eff_rs1;
    logic [1:0]  w_eff_rs2;
    logic [1:0]  w_eff_rd;
    logic        w_raw;
    logic        w_waw;
    logic        w_stall;
    logic        w_issue;

    assign w_ret_act = wb_reg_wen_i && (wb_rd_addr_i != 5'd0);
    assign w_ret_ok  = w_ret_act && (r_cnt[wb_rd_addr_i] != 2'd0);

    // A register retiring this cycle is forwarded by regs, so it no longer counts as in flight.
    assign w_eff_rs1 = r_cnt[rs1_addr_i] - {1'b0, (w_ret_ok && (wb_rd_addr_i == rs1_addr_i))};
    assign w_eff_rs2 = r_cnt[rs2_addr_i] - {1'b0, (w_ret_ok && (wb_rd_addr_i == rs2_addr_i))};
    assign w_eff_rd  = r_cnt[rd_addr_i]  - {1'b0, (w_ret_ok && (wb_rd_addr_i == rd_addr_i))};

    assign w_raw = id_valid_i &&
                   ((rs1_used_i && (rs1_addr_i != 5'd0) && (w_eff_rs1 != 2'd0)) ||
                    (rs2_used_i && (rs2_addr_i != 5'd0) && (w_eff_rs2 != 2'd0)));
    assign w_waw = id_valid_i && reg_wen_i && (rd_addr_i != 5'd0) && (w_eff_rd == 2'd3);
    assign w_stall = w_raw || w_waw;

    always_comb begin
        w_next         = r_state;
        hold_pc_o      = 1'b0;
        hold_if_id_o   = 1'b0;
        bubble_id_ex_o = 1'b0;
        flush_if_id_o  = 1'b0;
        flush_id_ex_o  = 1'b0;
        jump_fire_o    = 1'b0;
        case (r_state)
            JPEND: begin
                flush_if_id_o = 1'b1;
                flush_id_ex_o = 1'b1;
                if (hold_req_i) begin
                    hold_pc_o    = 1'b1;
                    hold_if_id_o = 1'b1;
                end else begin
                    jump_fire_o = 1'b1;
                    w_next      = RUN;
                end
            end
            default: begin
                // RUN, RAW and BUS share one priority ladder; the state only records why we hold.
                if (jump_en_i) begin
                    flush_if_id_o = 1'b1;
                    flush_id_ex_o = 1'b1;
                    if (hold_req_i) begin
                        hold_pc_o    = 1'b1;
                        hold_if_id_o = 1'b1;
                        w_next       = JPEND;
                    end else begin
                        jump_fire_o = 1'b1;
                        w_next      = RUN;
                    end
                end else if (hold_req_i) begin
                    hold_pc_o      = 1'b1;
                    hold_if_id_o   = 1'b1;
                    bubble_id_ex_o = 1'b1;
                    w_next         = BUS;
                end else if (w_stall) begin
                    hold_pc_o      = 1'b1;
                    hold_if_id_o   = 1'b1;
                    bubble_id_ex_o = 1'b1;
                    w_next         = RAW;
                end else begin
                    w_next = RUN;
                end
            end
        endcase
    end

    assign w_issue = id_valid_i && reg_wen_i && (rd_addr_i != 5'd0) && !hold_pc_o && !flush_id_ex_o;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= RUN;
            r_stall_cnt <= 32'd0;
            r_sb_err    <= 1'b0;
            for (int i = 0; i < 32; i++) begin
                r_cnt[i] <= 2'd0;
            end
        end else begin
            r_state     <= w_next;
            r_stall_cnt <= r_stall_cnt + {31'd0, hold_pc_o};
            if (w_ret_act && !w_ret_ok) begin
                r_sb_err <= 1'b1;
            end
            r_cnt[0] <= 2'd0;
            for (int i = 1; i < 32; i++) begin
                r_cnt[i] <= r_cnt[i]
                          + {1'b0, (w_issue && (rd_addr_i == i[4:0]))}
                          - {1'b0, (w_ret_ok && (wb_rd_addr_i == i[4:0]))};
            end
        end
    end

    assign state_o     = r_state;
    assign stall_cnt_o = r_stall_cnt;
    assign sb_err_o    = r_sb_err;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed hazard scenarios plus random traffic, all checked each cycle
// against an in-flight-count / pending-redirect reference model.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid_i;
    logic [4:0]  rs1_addr_i, rs2_addr_i, rd_addr_i, wb_rd_addr_i;
    logic        rs1_used_i, rs2_used_i, reg_wen_i, wb_reg_wen_i;
    logic        jump_en_i, hold_req_i;
    logic        hold_pc_o, hold_if_id_o, bubble_id_ex_o;
    logic        flush_if_id_o, flush_id_ex_o, jump_fire_o;
    logic [1:0]  state_o;
    logic [31:0] stall_cnt_o;
    logic        sb_err_o;

    int          n_checks = 0;
    int          n_fail   = 0;

    int          m_cnt [32];
    bit          m_pend;
    int          m_state;
    logic [31:0] m_stall;
    bit          m_err;

    always #5 clk = ~clk;

    hazard_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .id_valid_i    (id_valid_i),
        .rs1_addr_i    (rs1_addr_i),
        .rs2_addr_i    (rs2_addr_i),
        .rs1_used_i    (rs1_used_i),
        .rs2_used_i    (rs2_used_i),
        .rd_addr_i     (rd_addr_i),
        .reg_wen_i     (reg_wen_i),
        .wb_rd_addr_i  (wb_rd_addr_i),
        .wb_reg_wen_i  (wb_reg_wen_i),
        .jump_en_i     (jump_en_i),
        .hold_req_i    (hold_req_i),
        .hold_pc_o     (hold_pc_o),
        .hold_if_id_o  (hold_if_id_o),
        .bubble_id_ex_o(bubble_id_ex_o),
        .flush_if_id_o (flush_if_id_o),
        .flush_id_ex_o (flush_id_ex_o),
        .jump_fire_o   (jump_fire_o),
        .state_o       (state_o),
        .stall_cnt_o   (stall_cnt_o),
        .sb_err_o      (sb_err_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_cnt[i] = 0;
        m_pend  = 0;
        m_state = 0;
        m_stall = 32'd0;
        m_err   = 0;
    endtask

    function automatic int in_flight(input logic [4:0] r);
        int n;
        if (r == 5'd0) return 0;
        n = m_cnt[r];
        if (wb_reg_wen_i && wb_rd_addr_i == r && n > 0) n = n - 1;
        return n;
    endfunction

    // One clock: check outputs mid-cycle against the model, then advance the model past the edge.
    task automatic cyc();
        bit stall, e_hpc, e_hif, e_bub, e_fl, e_fire, issue, nxt_pend;
        int nxt_state;
        #2;
        stall = id_valid_i &&
                ((rs1_used_i && in_flight(rs1_addr_i) > 0) ||
                 (rs2_used_i && in_flight(rs2_addr_i) > 0) ||
                 (reg_wen_i && rd_addr_i != 5'd0 && in_flight(rd_addr_i) >= 3));
        e_hpc = 0; e_bub = 0; e_fl = 0; e_fire = 0;
        nxt_pend = 0;
        if (m_pend || jump_en_i) begin
            e_fl = 1;
            if (hold_req_i) begin
                e_hpc    = 1;
                nxt_pend = 1;
            end else begin
                e_fire = 1;
            end
        end else if (hold_req_i || stall) begin
            e_hpc = 1;
            e_bub = 1;
        end
        e_hif = e_hpc;
        if (nxt_pend)                      nxt_state = 3;
        else if (e_fl)                     nxt_state = 0;
        else if (hold_req_i)               nxt_state = 2;
        else if (stall)                    nxt_state = 1;
        else                               nxt_state = 0;
        issue = id_valid_i && reg_wen_i && rd_addr_i != 5'd0 && !e_hpc && !e_fl;

        check("hold_pc",     32'(hold_pc_o),      32'(e_hpc));
        check("hold_if_id",  32'(hold_if_id_o),   32'(e_hif));
        check("bubble",      32'(bubble_id_ex_o), 32'(e_bub));
        check("flush_if_id", 32'(flush_if_id_o),  32'(e_fl));
        check("flush_id_ex", 32'(flush_id_ex_o),  32'(e_fl));
        check("jump_fire",   32'(jump_fire_o),    32'(e_fire));
        check("state",       32'(state_o),        32'(m_state));
        check("stall_cnt",   stall_cnt_o,         m_stall);
        check("sb_err",      32'(sb_err_o),       32'(m_err));

        @(posedge clk);
        #1;
        if (rst) begin
            model_reset();
        end else begin
            m_stall = m_stall + 32'(e_hpc);
            if (wb_reg_wen_i && wb_rd_addr_i != 5'd0) begin
                if (m_cnt[wb_rd_addr_i] == 0) m_err = 1;
                else m_cnt[wb_rd_addr_i] = m_cnt[wb_rd_addr_i] - 1;
            end
            if (issue) m_cnt[rd_addr_i] = m_cnt[rd_addr_i] + 1;
            m_pend  = nxt_pend;
            m_state = nxt_state;
        end
    endtask

    task automatic step(input logic v, input logic [4:0] r1, input logic u1,
                        input logic [4:0] r2, input logic u2, input logic [4:0] rd,
                        input logic wen, input logic [4:0] wrd, input logic wwen,
                        input logic j, input logic h);
        id_valid_i   = v;   rs1_addr_i = r1; rs1_used_i = u1;
        rs2_addr_i   = r2;  rs2_used_i = u2; rd_addr_i  = rd; reg_wen_i = wen;
        wb_rd_addr_i = wrd; wb_reg_wen_i = wwen;
        jump_en_i    = j;   hold_req_i = h;
        cyc();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic retire(input logic [4:0] r);
        step(0, 0, 0, 0, 0, 0, 0, r, 1, 0, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
    endtask

    initial begin
        logic [4:0] r;
        bit         h;
        model_reset();
        m_pend = 0;
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(1);

        // producer x5, dependent reader stalls until retire, then issues in the retire cycle
        step(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0);
        step(1, 5, 1, 1, 1, 6, 1, 0, 0, 0, 0);
        step(1, 5, 1, 1, 1, 6, 1, 0, 0, 0, 0);
        step(1, 5, 1, 1, 1, 6, 1, 5, 1, 0, 0);
        retire(6);
        idle(1);

        // same-cycle retire forwards: no stall
        step(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0);
        step(1, 5, 1, 0, 0, 0, 0, 5, 1, 0, 0);
        idle(1);

        // WAW saturation on x7; x0 writes never counted
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 7, 1, 7, 1, 0, 0);
        for (int i = 0; i < 5; i++) step(1, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) retire(7);
        step(1, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0);

        // redirect during a RAW stall
        step(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0);
        step(1, 3, 1, 0, 0, 4, 1, 0, 0, 0, 0);
        step(1, 3, 1, 0, 0, 4, 1, 0, 0, 1, 0);
        step(1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        retire(3);
        step(1, 3, 1, 4, 1, 0, 0, 0, 0, 0, 0);

        // bus hold with redirect latched, fires once hold drops
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(2);

        // underflow is sticky until reset; reset also drops a pending redirect
        retire(9);
        idle(3);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        do_reset();
        idle(1);

        h = 0;
        for (int n = 0; n < 600; n++) begin
            id_valid_i = ($urandom_range(0, 3) != 0);
            rs1_addr_i = 5'($urandom_range(0, 7));
            rs2_addr_i = 5'($urandom_range(0, 7));
            rs1_used_i = 1'($urandom_range(0, 1));
            rs2_used_i = 1'($urandom_range(0, 1));
            rd_addr_i  = 5'($urandom_range(0, 7));
            reg_wen_i  = ($urandom_range(0, 3) != 0);
            r = 5'($urandom_range(1, 7));
            wb_rd_addr_i = r;
            wb_reg_wen_i = (m_cnt[r] > 0) && ($urandom_range(0, 1) == 1);
            h = h ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 6) == 0);
            hold_req_i = h;
            jump_en_i  = !m_pend && ($urandom_range(0, 11) == 0);
            rst = (n == 300);
            cyc();
        end
        rst = 1'b0;
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the RV32 core. It keeps a per-register scoreboard of in-flight writes and stalls the decode stage on RAW and WAW hazards. It arbitrates pipeline holds from the instruction bus against redirects from execute, and drives hold, bubble and flush controls for pc, if_id and id_ex. It sits beside id and consumes id's decoded register addresses and write enable.

## Interface
- No parameters; register count fixed at 32 and scoreboard counters fixed at 2 bits.
- clk  in  1  core clock
- rst  in  1  synchronous reset, active-high
- id_valid_i  in  1  if_id holds a valid instruction
- rs1_addr_i / rs2_addr_i  in  5  source registers from id
- rs1_used_i / rs2_used_i  in  1  instruction actually reads rs1/rs2
- rd_addr_i  in  5  destination from id
- reg_wen_i  in  1  id instruction writes rd
- wb_rd_addr_i  in  5  retiring write address
- wb_reg_wen_i  in  1  retiring write enable, one pulse per retire
- jump_en_i  in  1  execute redirect, one-cycle pulse
- hold_req_i  in  1  instruction bus not ready; level
- hold_pc_o, hold_if_id_o  out  1  freeze pc / if_id
- bubble_id_ex_o  out  1  load nop into id_ex
- flush_if_id_o, flush_id_ex_o  out  1  squash if_id / id_ex
- jump_fire_o  out  1  pc may take the redirect target this cycle
- state_o  out  2  RUN=0, RAW=1, BUS=2, JPEND=3
- stall_cnt_o  out  32  count of cycles with hold_pc_o=1
- sb_err_o  out  1  sticky scoreboard underflow

## Operation
- Scoreboard: cnt[1..31], 2 bits each; cnt[0] is hardwired to 0.
  - Issue: id_valid_i, reg_wen_i, rd≠0, no stall and no flush in the cycle → cnt[rd]+1.
  - Retire: wb_reg_wen_i and wb_rd≠0 → cnt[wb_rd]−1.
  - Issue and retire to the same rd in the same cycle → net unchanged.
  - Retire with cnt=0 → counter unchanged and sb_err_o set; only rst clears sb_err_o.
- Effective count eff[r] = cnt[r] minus this cycle's retire match. regs forwards same-cycle writes, so a source retiring this cycle does not stall.
- RAW stall when id_valid_i and either of the following holds:
  - rs1_used_i, rs1≠0 and eff[rs1]≠0
  - rs2_used_i, rs2≠0 and eff[rs2]≠0
- WAW stall when id_valid_i, reg_wen_i, rd≠0 and eff[rd]=3 (saturation).
- Priority per cycle: jump_en_i > hold_req_i > RAW/WAW stall > normal issue.
- FSM states and transitions:
  - RUN: on jump_en_i with hold_req_i=0, assert flushes and jump_fire_o and stay in RUN. On jump_en_i with hold_req_i=1, go to JPEND. On hold_req_i alone, go to BUS. On a stall, go to RAW.
  - RAW: assert hold_pc_o, hold_if_id_o and bubble_id_ex_o. Return to RUN in the cycle the stall condition clears (combinational release, no extra cycle). jump_en_i squashes the stalled instruction, which is never counted.
  - BUS: assert hold_pc_o and hold_if_id_o, and bubble_id_ex_o (no issue). Exit when hold_req_i drops: to RAW if a stall is pending, else RUN. jump_en_i while in BUS goes to JPEND.
  - JPEND: the latched redirect. Hold outputs stay asserted, and flush_if_id_o/flush_id_ex_o are asserted every cycle. When hold_req_i drops, pulse jump_fire_o for one cycle and go to RUN. Execute holds the jump target stable until jump_fire_o.
- stall_cnt_o increments each cycle hold_pc_o=1 and wraps 0xFFFFFFFF→0.

## Timing
- Reset values: all cnt=0, state RUN, stall_cnt_o=0, sb_err_o=0, all hold/flush/bubble/jump_fire outputs 0.
- Control outputs are combinational from the inputs and registered state, valid in the same cycle. Scoreboard, state and counters update on the rising clk edge.
- Stall latency is 0 cycles: the hazard is detected in the same cycle id presents the instruction.
- A RAW on a single producer stalls until the retire cycle. Issue occurs in the retire cycle via forwarding.
- rst mid-operation clears everything in one edge, including a pending jump.

## Test plan
- addi x5 issued, then add x6,x5,x1 decoded the next cycle with retire 2 cycles later → hold_pc_o=1 for exactly 2 cycles, then issue; cnt[5] ends at 0.
- Retire of x5 in the same cycle as decode of a reader of x5 → no stall, hold_pc_o=0.
- Three writes to x7 in flight (cnt=3) and a fourth decoded → WAW stall until one retire; x0 writes are never counted or stalled.
- jump_en_i during RAW stall → flush_if_id_o=flush_id_ex_o=jump_fire_o=1, state RUN, scoreboard unchanged.
- hold_req_i high 4 cycles with jump_en_i in cycle 2 → JPEND; jump_fire_o pulses 1 cycle after hold drops; stall_cnt_o=4 or more.
- Retire x9 with cnt[9]=0 → sb_err_o=1 and held until rst.
